// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and match helpers for the pipeline hazard controller
package pipe_pkg;

    localparam int SLOT_AW = 5;
    localparam logic [SLOT_AW-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic               valid;
        logic [SLOT_AW-1:0] dst;
        logic [SLOT_AW-1:0] rs;
        logic [SLOT_AW-1:0] rt;
        logic               useRs;
        logic               useRt;
        logic               regWrite;
        logic               memRead;
        logic               memWrite;
    } shadow_slot_t;

    // r0 is hardwired to zero, so a producer targeting it never creates a dependency.
    function automatic logic hazardMatch(input shadow_slot_t s, input logic [SLOT_AW-1:0] src,
                                         input logic useSrc);
        return useSrc && s.valid && s.regWrite && (s.dst != REG_ZERO) && (s.dst == src);
    endfunction

    // A load still in MEM has no data yet, so only WB may satisfy it.
    function automatic fwd_sel_t fwdSelect(input shadow_slot_t memS, input shadow_slot_t wbS,
                                           input logic [SLOT_AW-1:0] src, input logic useSrc);
        if (hazardMatch(memS, src, useSrc) && !memS.memRead) begin
            return FWD_MEM;
        end
        if (hazardMatch(wbS, src, useSrc)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_shadow_slot.sv
// rtl/hazard_shadow_slot.sv - one shadow pipeline register tracking register-use info of a stage
module hazard_shadow_slot
    import pipe_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         flush,
    input  shadow_slot_t d,
    output shadow_slot_t q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall, flush, memory-wait and forwarding control for the 5-stage pipeline
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MEM_LAT = 1,
    parameter int FWD_EN  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              redirect_mem,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_en,
    output logic              exmem_en,
    output logic              memwb_en,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              exmem_flush,
    output logic              memwb_flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_busy
);

    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    shadow_slot_t       idSlot;
    shadow_slot_t       exSlot;
    shadow_slot_t       memSlot;
    shadow_slot_t       wbSlot;
    logic [SLOT_AW-1:0] idRs;
    logic [SLOT_AW-1:0] idRt;
    logic [CNT_W-1:0]   waitCnt;
    logic               memBusy;
    logic               memEnter;
    logic               dataStall;
    fwd_sel_t           fwdA;
    fwd_sel_t           fwdB;

    assign idRs = SLOT_AW'(id_rs);
    assign idRt = SLOT_AW'(id_rt);

    always_comb begin
        idSlot          = '0;
        idSlot.valid    = id_valid;
        idSlot.dst      = SLOT_AW'(id_dst);
        idSlot.rs       = idRs;
        idSlot.rt       = idRt;
        idSlot.useRs    = id_use_rs;
        idSlot.useRt    = id_use_rt;
        idSlot.regWrite = id_regwrite;
        idSlot.memRead  = id_memread;
        idSlot.memWrite = id_memwrite;
    end

    hazard_shadow_slot uExSlot (
        .clk   (clk),
        .reset (reset),
        .en    (idex_en),
        .flush (idex_flush),
        .d     (idSlot),
        .q     (exSlot)
    );

    hazard_shadow_slot uMemSlot (
        .clk   (clk),
        .reset (reset),
        .en    (exmem_en),
        .flush (exmem_flush),
        .d     (exSlot),
        .q     (memSlot)
    );

    hazard_shadow_slot uWbSlot (
        .clk   (clk),
        .reset (reset),
        .en    (memwb_en),
        .flush (memwb_flush),
        .d     (memSlot),
        .q     (wbSlot)
    );

    // Without forwarding every in-flight producer blocks; with it only a load one stage ahead does.
    always_comb begin
        dataStall = 1'b0;
        if (id_valid) begin
            if (FWD_EN != 0) begin
                dataStall = exSlot.memRead &&
                            (hazardMatch(exSlot, idRs, id_use_rs) || hazardMatch(exSlot, idRt, id_use_rt));
            end else begin
                dataStall = hazardMatch(exSlot, idRs, id_use_rs)  || hazardMatch(exSlot, idRt, id_use_rt)  ||
                            hazardMatch(memSlot, idRs, id_use_rs) || hazardMatch(memSlot, idRt, id_use_rt) ||
                            hazardMatch(wbSlot, idRs, id_use_rs)  || hazardMatch(wbSlot, idRt, id_use_rt);
            end
        end
    end

    assign memBusy = (waitCnt != '0);

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (reset) begin
            if (memBusy) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_en    = 1'b0;
                memwb_flush = 1'b1;
            end else if (redirect_mem) begin
                ifid_flush  = 1'b1;
                idex_flush  = 1'b1;
                exmem_flush = 1'b1;
            end else if (dataStall) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end
    end

    assign mem_busy = memBusy;

    // The access occupies MEM for MEM_LAT cycles: the entry cycle plus MEM_LAT-1 frozen ones.
    assign memEnter = (MEM_LAT > 1) && exmem_en && !exmem_flush && exSlot.valid &&
                      (exSlot.memRead || exSlot.memWrite);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            waitCnt <= '0;
        end else if (memBusy) begin
            waitCnt <= waitCnt - CNT_W'(1);
        end else if (memEnter) begin
            waitCnt <= CNT_W'(MEM_LAT - 1);
        end
    end

    always_comb begin
        fwdA = FWD_RF;
        fwdB = FWD_RF;
        if (FWD_EN != 0) begin
            fwdA = fwdSelect(memSlot, wbSlot, exSlot.rs, exSlot.valid && exSlot.useRs);
            fwdB = fwdSelect(memSlot, wbSlot, exSlot.rt, exSlot.valid && exSlot.useRt);
        end
    end

    assign fwd_a = fwdA;
    assign fwd_b = fwdB;

    illegalRedirect: assert property (@(posedge clk) disable iff (!reset) !(redirect_mem && memBusy));

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed bench for pipe_hazard_ctrl across three parameter sets
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    // {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem,memwb flush | busy | fwd_a | fwd_b}
    localparam logic [13:0] NORMAL = 14'b11111_0000_0_0000;
    localparam logic [13:0] STALL  = 14'b00111_0100_0_0000;
    localparam logic [13:0] REDIR  = 14'b11111_1110_0_0000;
    localparam logic [13:0] BUSY   = 14'b00001_0001_1_0000;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_memwrite, redirect_mem;
    logic [4:0] id_rs, id_rt, id_dst;
    logic [2:0] pcEn, ifidEn, idexEn, exmemEn, memwbEn;
    logic [2:0] ifidFlush, idexFlush, exmemFlush, memwbFlush, memBusy;
    logic [1:0] fwdA [3];
    logic [1:0] fwdB [3];
    logic [13:0] mwExp [7];
    int passCnt = 0;
    int failCnt = 0;
    int totalCnt = 0;
    int busyCnt;
    int stallCnt;

    always #5 clk = ~clk;

    // Instance 0: forwarding, single-cycle memory. 1: MEM_LAT=3. 2: no forwarding.
    for (genvar g = 0; g < 3; g++) begin : gDut
        pipe_hazard_ctrl #(
            .REG_AW  (5),
            .MEM_LAT ((g == 1) ? 3 : 1),
            .FWD_EN  ((g == 2) ? 0 : 1)
        ) uDut (
            .clk          (clk),
            .reset        (reset),
            .id_valid     (id_valid),
            .id_rs        (id_rs),
            .id_rt        (id_rt),
            .id_use_rs    (id_use_rs),
            .id_use_rt    (id_use_rt),
            .id_dst       (id_dst),
            .id_regwrite  (id_regwrite),
            .id_memread   (id_memread),
            .id_memwrite  (id_memwrite),
            .redirect_mem (redirect_mem),
            .pc_en        (pcEn[g]),
            .ifid_en      (ifidEn[g]),
            .idex_en      (idexEn[g]),
            .exmem_en     (exmemEn[g]),
            .memwb_en     (memwbEn[g]),
            .ifid_flush   (ifidFlush[g]),
            .idex_flush   (idexFlush[g]),
            .exmem_flush  (exmemFlush[g]),
            .memwb_flush  (memwbFlush[g]),
            .fwd_a        (fwdA[g]),
            .fwd_b        (fwdB[g]),
            .mem_busy     (memBusy[g])
        );
    end

    function automatic logic [13:0] obsVec(input int k);
        return {pcEn[k], ifidEn[k], idexEn[k], exmemEn[k], memwbEn[k],
                ifidFlush[k], idexFlush[k], exmemFlush[k], memwbFlush[k], memBusy[k], fwdA[k], fwdB[k]};
    endfunction

    function automatic logic [13:0] fw(input logic [1:0] a, input logic [1:0] b);
        return {10'b0, a, b};
    endfunction

    task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input int k, input logic [13:0] exp);
        #1;
        chk(tag, obsVec(k), exp);
        @(negedge clk);
    endtask

    task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                         input logic urs, input logic urt, input logic rw, input logic mr, input logic mw);
        id_valid = v; id_rs = rs; id_rt = rt; id_dst = dst;
        id_use_rs = urs; id_use_rt = urt; id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    endtask

    task automatic rtype(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        setId(1'b1, s, t, d, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [4:0] d, input logic [4:0] b);
        setId(1'b1, b, d, d, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic store(input logic [4:0] t, input logic [4:0] b);
        setId(1'b1, b, t, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic branch(input logic [4:0] s, input logic [4:0] t);
        setId(1'b1, s, t, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic nop();
        setId(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        reset = 1'b0;
        redirect_mem = 1'b0;
        nop();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mwExp = '{BUSY, BUSY, NORMAL, BUSY, BUSY, NORMAL, NORMAL};
        reset = 1'b0;
        redirect_mem = 1'b1;
        rtype(5'd2, 5'd1, 5'd1);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs_%0d", k), obsVec(k), NORMAL);
        doReset();

        // lw $2,0($1); add $3,$2,$4
        load(5'd2, 5'd1);          cyc("lu_issue", 0, NORMAL);
        rtype(5'd3, 5'd2, 5'd4);   cyc("lu_stall", 0, STALL);
                                   cyc("lu_release", 0, NORMAL);
        nop();                     cyc("lu_fwd_wb", 0, NORMAL | fw(FWD_WB, FWD_RF));

        // add $2,$1,$1; sub $5,$2,$2
        doReset();
        rtype(5'd2, 5'd1, 5'd1);   cyc("raw_issue", 0, NORMAL);
        rtype(5'd5, 5'd2, 5'd2);   cyc("raw_no_stall", 0, NORMAL);
        nop();                     cyc("raw_fwd_mem", 0, NORMAL | fw(FWD_MEM, FWD_MEM));

        // add $2; add $2; or $6,$2,$0; add $0; add $8,$0,$0
        doReset();
        rtype(5'd2, 5'd1, 5'd1);   cyc("dbl_p1", 0, NORMAL);
        rtype(5'd2, 5'd3, 5'd3);   cyc("dbl_p2", 0, NORMAL);
        rtype(5'd6, 5'd2, 5'd0);   cyc("dbl_or", 0, NORMAL);
        rtype(5'd0, 5'd1, 5'd1);   cyc("dbl_mem_prio", 0, NORMAL | fw(FWD_MEM, FWD_RF));
        rtype(5'd8, 5'd0, 5'd0);   cyc("r0_no_stall", 0, NORMAL);
        nop();                     cyc("r0_no_fwd", 0, NORMAL);

        // beq taken in MEM while lw/add load-use sits in EX/ID
        doReset();
        branch(5'd1, 5'd2);        cyc("br_issue", 0, NORMAL);
        load(5'd2, 5'd1);          cyc("br_lw", 0, NORMAL);
        rtype(5'd3, 5'd2, 5'd4);
        redirect_mem = 1'b1;       cyc("br_redirect", 0, REDIR);
        redirect_mem = 1'b0;
        rtype(5'd9, 5'd2, 5'd2);   cyc("br_target", 0, NORMAL);
        nop();                     cyc("br_wb_only", 0, NORMAL);

        // MEM_LAT=3: sw then lw
        doReset();
        store(5'd5, 5'd1);         cyc("mw_sw", 1, NORMAL);
        load(5'd6, 5'd1);          cyc("mw_lw", 1, NORMAL);
        nop();
        busyCnt = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            if (memBusy[1]) busyCnt++;
            cyc($sformatf("mw_seq_%0d", i), 1, mwExp[i]);
        end
        chk("mw_busy_total", 14'(busyCnt), 14'd4);

        // reset asserted in the middle of a memory wait
        doReset();
        load(5'd6, 5'd1);          cyc("rst_lw", 1, NORMAL);
        nop();                     cyc("rst_lw_ex", 1, NORMAL);
        #1;
        chk("rst_busy_before", obsVec(1), BUSY);
        reset = 1'b0;
        #1;
        chk("rst_async_outputs", obsVec(1), NORMAL);
        @(negedge clk);
        reset = 1'b1;
        cyc("rst_released", 1, NORMAL);
        cyc("rst_wait_abandoned", 1, NORMAL);

        // FWD_EN=0: add $2; add $7,$2,$2
        doReset();
        rtype(5'd2, 5'd1, 5'd1);   cyc("nf_issue", 2, NORMAL);
        rtype(5'd7, 5'd2, 5'd2);
        stallCnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (!pcEn[2]) stallCnt++;
            cyc($sformatf("nf_step_%0d", i), 2, (i < 3) ? STALL : NORMAL);
        end
        nop();                     cyc("nf_after", 2, NORMAL);
        chk("nf_bubble_count", 14'(stallCnt), 14'd3);

        // invalid ID instruction never stalls
        doReset();
        rtype(5'd2, 5'd1, 5'd1);   cyc("iv_issue", 2, NORMAL);
        rtype(5'd7, 5'd2, 5'd2);
        id_valid = 1'b0;           cyc("iv_no_stall", 2, NORMAL);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
